// File: rtl/wb_cmd_master.sv
// Single-beat Wishbone classic master: takes one command at a time, drives the bus
// with retry/timeout handling, and returns one response per command.
module wb_cmd_master #(
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned AWIDTH    = 8,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [AWIDTH-1:0]     cmd_adr_i,
  input  logic [DWIDTH-1:0]     cmd_dat_i,
  input  logic [DWIDTH/8-1:0]   cmd_sel_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DWIDTH-1:0]     rsp_dat_o,
  output logic [1:0]            rsp_status_o,
  output logic [AWIDTH-1:0]     adr_o,
  output logic [DWIDTH-1:0]     dat_o,
  input  logic [DWIDTH-1:0]     dat_i,
  output logic                  we_o,
  output logic [DWIDTH/8-1:0]   sel_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  input  logic                  ack_i,
  input  logic                  err_i,
  input  logic                  rty_i
);

  localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_RTY = 2'b10;
  localparam logic [1:0] ST_TMO = 2'b11;

  typedef enum logic [1:0] {IDLE, BUS, GAP, RESP} state_e;

  state_e                state_q, state_d;
  logic [RW-1:0]         rty_cnt_q, rty_cnt_d;
  logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DWIDTH-1:0]     rsp_dat_q, rsp_dat_d;
  logic [1:0]            rsp_status_q, rsp_status_d;
  logic [AWIDTH-1:0]     adr_q, adr_d;
  logic [DWIDTH-1:0]     dat_q, dat_d;
  logic                  we_q, we_d;
  logic [DWIDTH/8-1:0]   sel_q, sel_d;
  logic                  cyc_q, cyc_d;
  logic                  stb_q, stb_d;
  logic                  to_resp;

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    rty_cnt_d    = rty_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    cmd_ready_d  = cmd_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    we_d         = we_q;
    sel_d        = sel_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    to_resp      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          adr_d       = cmd_adr_i;
          dat_d       = cmd_dat_i;
          we_d        = cmd_we_i;
          sel_d       = cmd_sel_i;
          rty_cnt_d   = '0;
          tmo_cnt_d   = '0;
          cmd_ready_d = 1'b0;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          state_d     = BUS;
        end
      end
      BUS: begin
        // Termination priority: err > ack > rty, then timeout
        to_resp = 1'b1;
        if (err_i) begin
          rsp_status_d = ST_ERR;
        end else if (ack_i) begin
          rsp_status_d = ST_OK;
        end else if (rty_i) begin
          if (rty_cnt_q == RW'(MAX_RETRY)) begin
            rsp_status_d = ST_RTY;
          end else begin
            to_resp   = 1'b0;
            rty_cnt_d = rty_cnt_q + RW'(1);
            cyc_d     = 1'b0;
            stb_d     = 1'b0;
            state_d   = GAP;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
          if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
            rsp_status_d = ST_TMO;
          end else begin
            to_resp = 1'b0;
          end
        end
        if (to_resp) begin
          rsp_dat_d   = (!err_i && ack_i && !we_q) ? dat_i : '0;
          rsp_valid_d = 1'b1;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          state_d     = RESP;
        end
      end
      GAP: begin
        tmo_cnt_d = '0;
        cyc_d     = 1'b1;
        stb_d     = 1'b1;
        state_d   = BUS;
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      rty_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= ST_OK;
      adr_q        <= '0;
      dat_q        <= '0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rty_cnt_q    <= rty_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_status_o = rsp_status_q;
  assign adr_o        = adr_q;
  assign dat_o        = dat_q;
  assign we_o         = we_q;
  assign sel_o        = sel_q;
  assign cyc_o        = cyc_q;
  assign stb_o        = stb_q;

endmodule
